// File: rtl/hls_deadlock_persist_monitor.sv
// Deadlock monitor for an HLS top: ORs AXIS and busy-instance block flags,
// filters for persistence and latches a sticky deadlock with debug capture.
module hls_deadlock_persist_monitor #(
    parameter int NUM_AXIS = 2,
    parameter int NUM_INST = 1,
    parameter int THRESH   = 16,
    localparam int INST_W  = (NUM_INST > 0) ? NUM_INST : 1,
    localparam int SRC_W   = NUM_AXIS + NUM_INST,
    localparam int CHAN_W  = (SRC_W > 1) ? $clog2(SRC_W) : 1,
    localparam int CNT_W   = $clog2(THRESH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic [INST_W-1:0]   inst_idle_sigs,
    input  logic [INST_W-1:0]   inst_block_sigs,
    input  logic                clear,
    output logic                block,
    output logic                deadlock,
    output logic [CHAN_W-1:0]   first_chan,
    output logic [SRC_W-1:0]    src_vec,
    output logic [CNT_W-1:0]    stall_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [SRC_W-1:0]   src;
    logic [SRC_W-1:0]   src_q;
    logic [CHAN_W-1:0]  chan_q;
    logic [CHAN_W-1:0]  low_idx;
    logic               any_block;
    logic               block_q;
    logic               lock_evt;

    // An instance only counts as blocked while it is actually busy.
    if (NUM_INST > 0) begin : g_inst
        assign src = {inst_block_sigs & ~inst_idle_sigs, axis_block_sigs};
    end else begin : g_no_inst
        logic unused_inst;
        assign unused_inst = ^{inst_idle_sigs, inst_block_sigs};
        assign src = axis_block_sigs;
    end

    assign any_block = |src;

    always_comb begin
        low_idx = '0;
        for (int i = SRC_W - 1; i >= 0; i--) begin
            if (src[i]) low_idx = CHAN_W'(i);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt_q   <= '0;
            block_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt_q   <= cnt_nxt;
            block_q <= any_block;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        if (clear) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_block) begin
                        state_nxt = (THRESH == 1) ? LOCKED : COUNT;
                        cnt_nxt   = ONE_C;
                    end
                end
                COUNT: begin
                    if (!any_block) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt_q + ONE_C == THRESH_C) begin
                        state_nxt = LOCKED;
                        cnt_nxt   = THRESH_C;
                    end else begin
                        cnt_nxt = cnt_q + ONE_C;
                    end
                end
                LOCKED: begin
                    state_nxt = LOCKED;
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        lock_evt   = (state_nxt == LOCKED) && (state != LOCKED);
        deadlock   = (state == LOCKED);
        block      = block_q;
        stall_cnt  = cnt_q;
        src_vec    = src_q;
        first_chan = chan_q;
    end

    // Debug capture reflects the sample on the edge that declared deadlock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            src_q  <= '0;
            chan_q <= '0;
        end else if (clear) begin
            src_q  <= '0;
            chan_q <= '0;
        end else if (lock_evt) begin
            src_q  <= src;
            chan_q <= low_idx;
        end
    end

endmodule

// File: tb/tb_hls_deadlock_persist_monitor.sv
// Bench for hls_deadlock_persist_monitor: THRESH=4 and THRESH=1 builds
// on shared inputs, checked against a run-length reference model.
module tb_hls_deadlock_persist_monitor;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] axis  = '0;
    logic       inst_b = 1'b0;
    logic       inst_i = 1'b0;
    logic       clr_s  = 1'b0;

    logic       b0, d0, b1, d1;
    logic [1:0] fc0, fc1;
    logic [2:0] sv0, sv1;
    logic [2:0] sc0;
    logic [0:0] sc1;

    int errors = 0;
    int checks = 0;

    int         run [2];
    logic       lk  [2];
    logic [2:0] vec [2];
    int         fc  [2];
    int         thr [2] = '{4, 1};
    logic       m_block;

    always #5 clock = ~clock;

    hls_deadlock_persist_monitor #(.NUM_AXIS(2), .NUM_INST(1), .THRESH(4)) dut (
        .clock(clock), .reset(reset), .axis_block_sigs(axis),
        .inst_idle_sigs(inst_i), .inst_block_sigs(inst_b), .clear(clr_s),
        .block(b0), .deadlock(d0), .first_chan(fc0), .src_vec(sv0),
        .stall_cnt(sc0));

    hls_deadlock_persist_monitor #(.NUM_AXIS(2), .NUM_INST(1), .THRESH(1)) dut1 (
        .clock(clock), .reset(reset), .axis_block_sigs(axis),
        .inst_idle_sigs(inst_i), .inst_block_sigs(inst_b), .clear(clr_s),
        .block(b1), .deadlock(d1), .first_chan(fc1), .src_vec(sv1),
        .stall_cnt(sc1));

    wire [9:0] obs0 = {b0, d0, fc0, sv0, sc0};
    wire [7:0] obs1 = {b1, d1, fc1, sv1, sc1};

    function automatic logic [9:0] exp0();
        return {m_block, lk[0], 2'(fc[0]), vec[0], 3'(run[0])};
    endfunction

    function automatic logic [7:0] exp1();
        return {m_block, lk[1], 2'(fc[1]), vec[1], 1'(run[1])};
    endfunction

    function automatic int lowest(input logic [2:0] v);
        for (int i = 0; i < 3; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_block = 1'b0;
        for (int k = 0; k < 2; k++) begin
            run[k] = 0; lk[k] = 1'b0; vec[k] = '0; fc[k] = 0;
        end
    endtask

    // Drive one cycle's inputs, let the edge happen, advance the model.
    task automatic step(input logic [1:0] a, input logic ib,
                        input logic ii, input logic clr);
        logic [2:0] s;
        axis = a; inst_b = ib; inst_i = ii; clr_s = clr;
        @(posedge clock);
        s = {ib & ~ii, a};
        m_block = |s;
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                run[k] = 0; lk[k] = 1'b0; vec[k] = '0; fc[k] = 0;
            end else if (!lk[k]) begin
                if (|s) begin
                    run[k]++;
                    if (run[k] == thr[k]) begin
                        lk[k] = 1'b1; vec[k] = s; fc[k] = lowest(s);
                    end
                end else begin
                    run[k] = 0;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (obs0 !== 10'd0 || obs1 !== 8'd0) begin
            errors++;
            $display("FAIL reset_async: got %h/%h want 0/0", obs0, obs1);
        end
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            step(2'b00, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs0 !== 10'd0 || obs1 !== 8'd0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got %h/%h want 0/0", i, obs0, obs1);
            end
        end
    endtask

    task automatic test_short_burst();
        for (int i = 0; i < 4; i++) begin
            step(i < 3 ? 2'b01 : 2'b00, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs0 !== exp0() || obs1 !== exp1()) begin
                errors++;
                $display("FAIL short_burst[%0d]: got %h/%h want %h/%h",
                         i, obs0, obs1, exp0(), exp1());
            end
        end
        checks++;
        if (sc0 !== 3'd0 || d0 !== 1'b0) begin
            errors++;
            $display("FAIL short_burst_end: cnt=%0d dl=%b want 0/0", sc0, d0);
        end
    endtask

    task automatic test_lock_axis();
        step(2'b00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(2'b10, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs0 !== exp0()) begin
                errors++;
                $display("FAIL lock_axis[%0d]: got %h want %h", i, obs0, exp0());
            end
        end
        checks++;
        if (d0 !== 1'b1 || fc0 !== 2'd1 || sv0 !== 3'b010 || sc0 !== 3'd4) begin
            errors++;
            $display("FAIL lock_axis_cap: dl=%b fc=%0d sv=%b cnt=%0d want 1/1/010/4",
                     d0, fc0, sv0, sc0);
        end
        for (int i = 0; i < 3; i++) step(2'b00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (b0 !== 1'b0 || d0 !== 1'b1 || sv0 !== 3'b010 || sc0 !== 3'd4
            || obs0 !== exp0()) begin
            errors++;
            $display("FAIL lock_axis_hold: got %h want %h", obs0, exp0());
        end
    endtask

    task automatic test_inst_idle();
        step(2'b00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(2'b00, 1'b1, 1'b1, 1'b0);
            checks++;
            if (b0 !== 1'b0 || sc0 !== 3'd0 || obs0 !== exp0()) begin
                errors++;
                $display("FAIL inst_idle[%0d]: got %h want %h", i, obs0, exp0());
            end
        end
        for (int i = 0; i < 4; i++) step(2'b00, 1'b1, 1'b0, 1'b0);
        checks++;
        if (d0 !== 1'b1 || fc0 !== 2'd2 || sv0 !== 3'b100 || obs0 !== exp0()) begin
            errors++;
            $display("FAIL inst_lock: dl=%b fc=%0d sv=%b want 1/2/100", d0, fc0, sv0);
        end
    endtask

    task automatic test_clear_relock();
        step(2'b11, 1'b0, 1'b0, 1'b1);
        checks++;
        if (d0 !== 1'b0 || sc0 !== 3'd0 || sv0 !== 3'b000 || fc0 !== 2'd0
            || b0 !== 1'b1) begin
            errors++;
            $display("FAIL clear: got %h want %h", obs0, exp0());
        end
        step(2'b11, 1'b0, 1'b0, 1'b0);
        checks++;
        if (sc0 !== 3'd1 || d0 !== 1'b0) begin
            errors++;
            $display("FAIL clear_restart: cnt=%0d dl=%b want 1/0", sc0, d0);
        end
        for (int i = 0; i < 3; i++) begin
            step(2'b11, 1'b0, 1'b0, 1'b0);
            checks++;
            if (obs0 !== exp0() || obs1 !== exp1()) begin
                errors++;
                $display("FAIL relock[%0d]: got %h/%h want %h/%h",
                         i, obs0, obs1, exp0(), exp1());
            end
        end
        checks++;
        if (d0 !== 1'b1 || fc0 !== 2'd0 || sv0 !== 3'b011) begin
            errors++;
            $display("FAIL relock_cap: dl=%b fc=%0d sv=%b want 1/0/011", d0, fc0, sv0);
        end
    endtask

    task automatic test_thresh1();
        step(2'b00, 1'b0, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0, 1'b0);
        checks++;
        if (b1 !== 1'b1 || d1 !== 1'b1 || sc1 !== 1'b1 || sv1 !== 3'b001
            || fc1 !== 2'd0) begin
            errors++;
            $display("FAIL thresh1: got %h want b=1 dl=1 cnt=1 sv=001", obs1);
        end
        step(2'b00, 1'b0, 1'b0, 1'b0);
        checks++;
        if (b1 !== 1'b0 || d1 !== 1'b1 || obs1 !== exp1()) begin
            errors++;
            $display("FAIL thresh1_hold: got %h want %h", obs1, exp1());
        end
    endtask

    task automatic test_async_reset();
        step(2'b00, 1'b0, 1'b0, 1'b1);
        step(2'b01, 1'b0, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0, 1'b0);
        checks++;
        if (sc0 !== 3'd2) begin
            errors++;
            $display("FAIL pre_reset_cnt: got %0d want 2", sc0);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (obs0 !== 10'd0 || obs1 !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: got %h/%h want 0/0", obs0, obs1);
        end
        axis = '0;
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        logic [1:0] a;
        logic ib, ii, clr;
        for (int i = 0; i < 400; i++) begin
            a   = 2'($urandom_range(0, 3));
            ib  = 1'($urandom);
            ii  = 1'($urandom);
            if ($urandom_range(0, 4) == 0) begin a = '0; ib = 1'b0; end
            clr = ($urandom_range(0, 15) == 0);
            step(a, ib, ii, clr);
            checks++;
            if (obs0 !== exp0() || obs1 !== exp1()) begin
                errors++;
                $display("FAIL random[%0d]: got %h/%h want %h/%h",
                         i, obs0, obs1, exp0(), exp1());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_short_burst();
        test_lock_axis();
        test_inst_idle();
        test_clear_relock();
        test_thresh1();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
